// File: rtl/seg7_pattern_reader.sv
// seg7_pattern_reader: watches an active-low 7-segment bus, waits for each
// pattern to settle, and decodes it back to a hex digit. The digit is offered
// downstream through a valid/ready handshake. The block also flags blank and
// illegal patterns, and raises a sticky flag when a digit is overwritten
// before it was taken.
module seg7_pattern_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       blank,
    output logic       illegal,
    output logic       overflow
);

    localparam logic [7:0] CntMax  = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SegBlank = 7'h7F;

    typedef enum logic [1:0] {
        StWaitChange,
        StSettling,
        StHold
    } state_e;

    state_e     state;
    logic [6:0] sync1;
    logic [6:0] s_seg;
    logic [6:0] prev_seg;
    logic [6:0] last_seg;
    logic [7:0] cnt;
    logic       seg_changed;
    logic       settled;
    logic       dec_ok;
    logic [3:0] dec_val;

    assign seg_changed = (s_seg != prev_seg);
    assign settled     = !seg_changed && (cnt == CntMax);

    // Synchronizer, previous-sample register and saturating stability counter.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1    <= SegBlank;
            s_seg    <= SegBlank;
            prev_seg <= SegBlank;
            cnt      <= 8'd0;
        end else begin
            sync1    <= seg;
            s_seg    <= sync1;
            prev_seg <= s_seg;
            if (seg_changed) begin
                cnt <= 8'd0;
            end else if (cnt != CntMax) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Decode the most recently settled pattern to its hex value.
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (last_seg)
            7'h40:   dec_val = 4'h0;
            7'h79:   dec_val = 4'h1;
            7'h24:   dec_val = 4'h2;
            7'h30:   dec_val = 4'h3;
            7'h19:   dec_val = 4'h4;
            7'h12:   dec_val = 4'h5;
            7'h02:   dec_val = 4'h6;
            7'h78:   dec_val = 4'h7;
            7'h00:   dec_val = 4'h8;
            7'h10:   dec_val = 4'h9;
            7'h08:   dec_val = 4'hA;
            7'h03:   dec_val = 4'hB;
            7'h46:   dec_val = 4'hC;
            7'h21:   dec_val = 4'hD;
            7'h06:   dec_val = 4'hE;
            7'h0E:   dec_val = 4'hF;
            default: dec_ok  = 1'b0;
        endcase
    end

    // Settle-detection FSM with registered classification and handshake outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state       <= StWaitChange;
            last_seg    <= SegBlank;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            illegal     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (digit_valid && digit_ready) begin
                digit_valid <= 1'b0;
            end
            unique case (state)
                StWaitChange: begin
                    if (s_seg != last_seg) begin
                        state <= StSettling;
                    end
                end
                StSettling: begin
                    if (seg_changed) begin
                        state <= StWaitChange;
                    end else if (settled) begin
                        state    <= StHold;
                        last_seg <= s_seg;
                    end
                end
                StHold: begin
                    state <= StWaitChange;
                    if (dec_ok) begin
                        // A new digit overrides any same-cycle accept; only an
                        // unaccepted pending digit counts as lost.
                        digit       <= dec_val;
                        digit_valid <= 1'b1;
                        blank       <= 1'b0;
                        illegal     <= 1'b0;
                        if (digit_valid && !digit_ready) begin
                            overflow <= 1'b1;
                        end
                    end else if (last_seg == SegBlank) begin
                        blank   <= 1'b1;
                        illegal <= 1'b0;
                    end else begin
                        blank   <= 1'b0;
                        illegal <= 1'b1;
                    end
                end
                default: state <= StWaitChange;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Testbench for seg7_pattern_reader: directed sequences, a table of vectors,
// and randomized stimulus checked every cycle against a reference model.
module tb_seg7_pattern_reader;

    localparam int unsigned S = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn, resetn1;
    logic [6:0] seg, seg1;
    logic       digit_ready, ready1;
    logic [3:0] digit, digit1;
    logic       digit_valid, valid1;
    logic       blank, blank1;
    logic       illegal, illegal1;
    logic       overflow, overflow1;

    int total = 0;
    int bad   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_pattern_reader #(.STABLE_CYCLES(S)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .seg         (seg),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blank       (blank),
        .illegal     (illegal),
        .overflow    (overflow)
    );

    seg7_pattern_reader #(.STABLE_CYCLES(1)) dut1 (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn1),
        .seg         (seg1),
        .digit       (digit1),
        .digit_valid (valid1),
        .digit_ready (ready1),
        .blank       (blank1),
        .illegal     (illegal1),
        .overflow    (overflow1)
    );

    logic [6:0] enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int ref_digit(logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (enc_tab[i] == p) return i;
        end
        return -1;
    endfunction

    // Reference model: pin samples, run length of the synchronized value,
    // and a two-edge delay from settle decision to visible outputs.
    logic [6:0] m_p1, m_s, m_last, ev1_pat, ev2_pat;
    int         m_run;
    logic       ev1_v, ev2_v;
    logic [3:0] m_digit;
    logic       m_valid, m_blank, m_illegal, m_ovf;

    task automatic model_step();
        int         d;
        logic [6:0] s_new;
        if (!resetn) begin
            m_p1 = 7'h7F; m_s = 7'h7F; m_last = 7'h7F; m_run = 2;
            ev1_v = 1'b0; ev2_v = 1'b0; ev1_pat = 7'h7F; ev2_pat = 7'h7F;
            m_digit = 4'h0; m_valid = 1'b0; m_blank = 1'b0; m_illegal = 1'b0; m_ovf = 1'b0;
        end else begin
            if (m_valid && digit_ready) m_valid = 1'b0;
            if (ev2_v) begin
                d = ref_digit(ev2_pat);
                if (d >= 0) begin
                    if (m_valid) m_ovf = 1'b1;
                    m_digit = 4'(d); m_valid = 1'b1; m_blank = 1'b0; m_illegal = 1'b0;
                end else if (ev2_pat == 7'h7F) begin
                    m_blank = 1'b1; m_illegal = 1'b0;
                end else begin
                    m_blank = 1'b0; m_illegal = 1'b1;
                end
            end
            ev2_v = ev1_v; ev2_pat = ev1_pat; ev1_v = 1'b0;
            s_new = m_p1;
            m_p1  = seg;
            m_run = (s_new == m_s) ? m_run + 1 : 1;
            m_s   = s_new;
            if (m_run >= int'(S) + 1 && m_s != m_last) begin
                ev1_v = 1'b1; ev1_pat = m_s; m_last = m_s;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: update the model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        check("model", {digit, digit_valid, blank, illegal, overflow},
              {m_digit, m_valid, m_blank, m_illegal, m_ovf});
    endtask

    task automatic accept_one();
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
    endtask

    typedef struct {
        logic [6:0] pat;
        logic [3:0] dg;
        logic       vld;
        logic       blk;
        logic       ill;
    } vec_t;

    vec_t       vecs [19];
    logic [6:0] pool [18];

    initial begin
        int n;
        int hold;

        vecs[0]  = '{7'h40, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{7'h79, 4'h1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{7'h24, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{7'h30, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{7'h19, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{7'h12, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{7'h02, 4'h6, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{7'h78, 4'h7, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{7'h00, 4'h8, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{7'h10, 4'h9, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{7'h08, 4'hA, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{7'h03, 4'hB, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{7'h46, 4'hC, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{7'h21, 4'hD, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{7'h06, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{7'h0E, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 4'hF, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{7'h55, 4'hF, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{7'h24, 4'h2, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) pool[i] = enc_tab[i];
        pool[16] = 7'h7F;
        pool[17] = 7'h55;

        // Reset with a blank bus.
        resetn = 1'b0; resetn1 = 1'b0; seg = 7'h7F; seg1 = 7'h7F;
        digit_ready = 1'b0; ready1 = 1'b0;
        tick(); tick();
        check("reset_outputs", {digit, digit_valid, blank, illegal, overflow}, 0);
        resetn = 1'b1; resetn1 = 1'b1;
        repeat (20) tick();
        check("no_event_after_reset", {digit_valid, blank, illegal}, 0);

        // Single-cycle stability: settles right after the change.
        seg1 = 7'h79;
        n = 0;
        while (!valid1 && n < 20) begin tick(); n++; end
        check("s1_latency", n - 1, 2 + 1 + 1);
        check("s1_digit", digit1, 4'h1);

        // Latency of a first digit.
        seg = 7'h24;
        n = 0;
        while (!digit_valid && n < 30) begin tick(); n++; end
        check("latency", n - 1, 2 + S + 1);
        check("latency_digit", digit, 4'h2);
        repeat (50) tick();
        check("hold_valid", {digit_valid, digit}, {1'b1, 4'h2});

        // Accept, no retrigger, then blank and the same digit again.
        accept_one();
        check("accept_clears", digit_valid, 1'b0);
        repeat (20) tick();
        check("no_retrigger", digit_valid, 1'b0);
        seg = 7'h7F;
        repeat (10) tick();
        check("blank_set", {blank, digit_valid}, {1'b1, 1'b0});
        seg = 7'h24;
        repeat (9) tick();
        check("second_digit", {digit_valid, digit, blank}, {1'b1, 4'h2, 1'b0});
        accept_one();

        // Glitchy toggling: only the final stable value counts.
        seg = 7'h40; repeat (3) tick();
        seg = 7'h79; repeat (3) tick();
        check("toggle_no_valid", digit_valid, 1'b0);
        seg = 7'h40;
        n = 0;
        while (!digit_valid && n < 30) begin tick(); n++; end
        check("toggle_latency", n - 1, 2 + S + 1);
        check("toggle_digit", digit, 4'h0);

        // Illegal pattern, then lost digits.
        seg = 7'h55; repeat (9) tick();
        check("illegal_flag", {illegal, blank, digit_valid, digit}, {1'b1, 1'b0, 1'b1, 4'h0});
        seg = 7'h12; repeat (9) tick();
        check("overwrite_5", {digit, overflow, illegal}, {4'h5, 1'b1, 1'b0});
        seg = 7'h06; repeat (9) tick();
        check("overwrite_e", {digit, digit_valid, overflow}, {4'hE, 1'b1, 1'b1});

        // Reset in the middle of a settle.
        seg = 7'h21; repeat (3) tick();
        resetn = 1'b0; tick();
        check("reset_mid_settle", {digit, digit_valid, blank, illegal, overflow}, 0);
        resetn = 1'b1;

        // New digit lands in the same cycle as an accept: no overflow.
        seg = 7'h24; repeat (9) tick();
        check("pre_same_cycle", {digit_valid, digit}, {1'b1, 4'h2});
        seg = 7'h30;
        repeat (7) tick();
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
        check("same_cycle_accept", {digit_valid, digit, overflow}, {1'b1, 4'h3, 1'b0});
        accept_one();

        // Table sweep of every pattern class.
        for (int i = 0; i < 19; i++) begin
            seg = vecs[i].pat;
            repeat (9) tick();
            check($sformatf("vec%0d", i), {digit, digit_valid, blank, illegal, overflow},
                  {vecs[i].dg, vecs[i].vld, vecs[i].blk, vecs[i].ill, 1'b0});
            accept_one();
        end

        // Randomized patterns, hold times, ready and occasional reset.
        for (int k = 0; k < 400; k++) begin
            seg  = pool[$urandom_range(0, 17)];
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                digit_ready = ($urandom_range(0, 2) == 0);
                resetn      = ($urandom_range(0, 150) != 0);
                tick();
            end
        end
        resetn = 1'b1;
        digit_ready = 1'b0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
- Reverse direction of the team's hex-to-7-segment driver. Watches an active-low 7-segment segment bus and waits for each pattern to settle.
- Decodes a settled pattern back to its 4-bit hex digit and hands it to downstream logic through a valid/ready handshake.
- Flags illegal patterns and lost digits.
- Used for loopback checking of display paths and for reading segment patterns entered on switches.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples needed before a pattern counts as settled (legal range 1..255).

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- seg  input  7  active-low segment bus; bit 0 = segment a ... bit 6 = segment g.
- digit  output  4  decoded hex value.
- digit_valid  output  1  digit holds an undelivered value.
- digit_ready  input  1  consumer accepts digit when high together with digit_valid.
- blank  output  1  settled pattern is 7'h7F (all segments off).
- illegal  output  1  settled pattern is neither a legal digit nor blank.
- overflow  output  1  sticky flag: a digit was dropped.

Behaviour:
- Legal encodings (seg -> digit):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
- Input stage: seg passes through a 2-flop synchronizer; s_seg is the second flop. All later logic uses s_seg.
- Stability counter:
  - An 8-bit counter resets to 0 whenever s_seg differs from its value in the previous cycle; otherwise it increments.
  - It saturates at STABLE_CYCLES-1.
  - The pattern counts as settled in the cycle the counter reaches STABLE_CYCLES-1 with an unchanged s_seg.
- A settled pattern is processed exactly once. Pattern register last_seg stores the most recently processed pattern. The same pattern is not reprocessed until a different pattern has settled.
- FSM states: WAIT_CHANGE, SETTLING, HOLD.
  - WAIT_CHANGE -> SETTLING when s_seg != last_seg.
  - SETTLING -> WAIT_CHANGE if s_seg changes (counter restarts).
  - SETTLING -> HOLD on settle: last_seg <= s_seg, classify the pattern, registered outputs update next cycle.
  - HOLD -> WAIT_CHANGE after one cycle.
- Classification outputs:
  - Legal digit: digit <= value, digit_valid <= 1, blank <= 0, illegal <= 0.
  - 7'h7F: blank <= 1, illegal <= 0; digit and digit_valid unchanged.
  - Any other pattern: illegal <= 1, blank <= 0; digit and digit_valid unchanged.
- Latency: a pattern stable from cycle t at the seg pins produces digit_valid high at cycle t + 2 + STABLE_CYCLES + 1 (2 sync flops, settle, registered output).
- Handshake:
  - digit_valid stays high and digit stays constant until the cycle digit_valid & digit_ready is sampled; digit_valid clears on the next edge.
  - digit_ready while digit_valid is low is ignored.
- Boundary cases:
  - New legal digit settles while digit_valid=1 and digit_ready=0: digit is overwritten with the new value, digit_valid stays 1, overflow <= 1 (sticky).
  - New legal digit settles in the same cycle as an accept: no overflow; digit_valid stays 1 with the new digit.
  - Glitch shorter than STABLE_CYCLES cycles: no output change.
  - STABLE_CYCLES=1: settles on the first cycle after a change, provided s_seg is unchanged.
- Reset (resetn low at any rising edge, including mid-settle or mid-handshake):
  - digit=0, digit_valid=0, blank=0, illegal=0, overflow=0.
  - Counter=0; synchronizer flops=7'h7F.
  - last_seg=7'h7F, so a blank bus after reset produces no event.
  - State=WAIT_CHANGE.
- overflow clears only on reset.

Test Plan:
- Reset with seg=7F held -> all outputs 0; no event for 20 cycles.
- seg=7'h24 held, digit_ready=0, STABLE_CYCLES=4 -> digit_valid rises exactly 7 cycles after the seg change with digit=2; stays high with digit=2 for 50 cycles.
- Same pattern, then digit_ready=1 for one cycle -> digit_valid low next cycle; no re-trigger while seg stays 24. Then seg=7F, then 24 again -> second digit=2 delivered.
- seg toggles 40->79->40, 3 cycles per value, ending on 40 -> no valid until 40 holds 4 cycles; then digit=0.
- Sweep all 16 legal patterns with digit_ready held 1 -> digits 0..F in order; illegal=0 and overflow=0 throughout.
- seg=7'h55 settles -> illegal=1 with digit_valid unchanged. Next, seg=12 then seg=06 without accepting -> digit=E, overflow=1. Assert resetn=0 mid-settle -> all outputs clear next edge.
